// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with an optional return stack.
//
// All state changes on the falling edge of Clk. Reset (nReset) is
// asynchronous and active-high. Exactly one operation runs per edge,
// priority Load > Ret > Call > Branch > CountEn; with none requested Y holds.
//
// Build option: define PC_SEQUENCER_STACK_EN to include the return stack
// (Call/Ret, Full/Empty, Err). Without it Call and Ret are ignored,
// Full = 0, Empty = 1 and Err = 0.
//
// Parameters:
//   WIDTH   program counter / address width (4..32)
//   DEPTH   return-stack entries (1..16)
//   STEP    unsigned increment used by CountEn and for the Call return address
// Ports:
//   Clk      clock, falling-edge active
//   nReset   asynchronous reset, active-high
//   A        Load / Call target address
//   Offset   two's-complement relative Branch offset
//   Load, Ret, Call, Branch, CountEn   operation requests
//   Y        registered program counter
//   Full     stack pointer == DEPTH (combinational)
//   Empty    stack pointer == 0 (combinational)
//   Wrap     one-cycle registered pulse when a CountEn increment carries out
//   Err      one-cycle registered pulse on a stack overflow/underflow attempt
module pc_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int STEP  = 1
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Offset,
  input  logic             Load,
  input  logic             Ret,
  input  logic             Call,
  input  logic             Branch,
  input  logic             CountEn,
  output logic [WIDTH-1:0] Y,
  output logic             Full,
  output logic             Empty,
  output logic             Wrap,
  output logic             Err
);

  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] y_next_s;
  logic             wrap_r;
  logic             wrap_next_s;
  // Y + STEP with the carry kept in the top bit.
  logic [WIDTH:0]   inc_s;

  assign inc_s = {1'b0, y_r} + (WIDTH+1)'(STEP);

`ifdef PC_SEQUENCER_STACK_EN
  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0]    sp_r;
  logic [PW-1:0]    sp_next_s;
  logic [PW-1:0]    sp_dec_s;
  // Sized to the full pointer range so the pointer indexes it directly.
  logic [WIDTH-1:0] stack_r [2**PW];
  logic [WIDTH-1:0] top_s;
  logic             push_s;
  logic             full_s;
  logic             empty_s;
  logic             err_r;
  logic             err_next_s;

  assign sp_dec_s = sp_r - PW'(1'b1);
  assign top_s    = stack_r[sp_dec_s];
  assign full_s   = (sp_r == PW'(DEPTH));
  assign empty_s  = (sp_r == {PW{1'b0}});
  assign Full     = full_s;
  assign Empty    = empty_s;
  assign Err      = err_r;
`else
  logic unused_call_ret_s;

  assign unused_call_ret_s = Ret ^ Call;
  assign Full  = 1'b0;
  assign Empty = 1'b1;
  assign Err   = 1'b0;
`endif

  assign Y    = y_r;
  assign Wrap = wrap_r;

  // Next-state selection in priority order Load > Ret > Call > Branch > CountEn.
  always_comb begin
    y_next_s    = y_r;
    wrap_next_s = 1'b0;
`ifdef PC_SEQUENCER_STACK_EN
    sp_next_s   = sp_r;
    push_s      = 1'b0;
    err_next_s  = 1'b0;
`endif
    if (Load) begin
      y_next_s = A;
    end
`ifdef PC_SEQUENCER_STACK_EN
    else if (Ret) begin
      if (!empty_s) begin
        y_next_s  = top_s;
        sp_next_s = sp_dec_s;
      end else begin
        err_next_s = 1'b1;
      end
    end else if (Call) begin
      if (!full_s) begin
        push_s    = 1'b1;
        y_next_s  = A;
        sp_next_s = sp_r + PW'(1'b1);
      end else begin
        err_next_s = 1'b1;
      end
    end
`endif
    else if (Branch) begin
      // Equal-width modular add is the same as adding the sign-extended offset.
      y_next_s = y_r + Offset;
    end else if (CountEn) begin
      {wrap_next_s, y_next_s} = inc_s;
    end else begin
      y_next_s = y_r;
    end
  end

  // Program counter and wrap pulse register.
  always_ff @(negedge Clk or posedge nReset) begin
    if (nReset) begin
      y_r    <= {WIDTH{1'b0}};
      wrap_r <= 1'b0;
    end else begin
      y_r    <= y_next_s;
      wrap_r <= wrap_next_s;
    end
  end

`ifdef PC_SEQUENCER_STACK_EN
  // Stack pointer and error pulse register.
  always_ff @(negedge Clk or posedge nReset) begin
    if (nReset) begin
      sp_r  <= {PW{1'b0}};
      err_r <= 1'b0;
    end else begin
      sp_r  <= sp_next_s;
      err_r <= err_next_s;
    end
  end

  // Return-address storage; contents survive reset, only the pointer clears.
  always_ff @(negedge Clk) begin
    if (push_s) begin
      stack_r[sp_r] <= inc_s[WIDTH-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer (WIDTH=8, DEPTH=2, STEP=1): a directed vector
// table, hand-written stack/reset sequences, then random stimulus compared
// against a queue-based reference model.
module tb_pc_sequencer;

  localparam int TB_WIDTH = 8;
  localparam int TB_DEPTH = 2;
  localparam int TB_STEP  = 1;
`ifdef PC_SEQUENCER_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic       Clk = 1'b1;
  logic       nReset = 1'b1;
  logic [7:0] A = 8'h00;
  logic [7:0] Offset = 8'h00;
  logic       Load = 1'b0, Ret = 1'b0, Call = 1'b0, Branch = 1'b0, CountEn = 1'b0;
  logic [7:0] Y;
  logic       Full, Empty, Wrap, Err;

  int tests = 0;
  int failed = 0;

  pc_sequencer #(.WIDTH(TB_WIDTH), .DEPTH(TB_DEPTH), .STEP(TB_STEP)) dut (
    .Clk(Clk), .nReset(nReset), .A(A), .Offset(Offset),
    .Load(Load), .Ret(Ret), .Call(Call), .Branch(Branch), .CountEn(CountEn),
    .Y(Y), .Full(Full), .Empty(Empty), .Wrap(Wrap), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       load, ret, call, branch, counten;
    logic [7:0] a, offset, exp_y;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs [14];

  // Reference model state
  int m_y;
  int m_stk[$];
  bit m_wrap, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request, let the falling edge take it, sample 1 time unit later.
  task automatic apply(input logic l, input logic r, input logic c, input logic b,
                       input logic ce, input logic [7:0] a_v, input logic [7:0] off_v);
    Load = l; Ret = r; Call = c; Branch = b; CountEn = ce; A = a_v; Offset = off_v;
    @(negedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Load = 1'b0; Ret = 1'b0; Call = 1'b0; Branch = 1'b0; CountEn = 1'b0;
  endtask

  // Assert reset between clock edges, check the reset state, release on a rising edge.
  task automatic do_reset(input string tag);
    #2;
    nReset = 1'b1;
    #1;
    check({tag, " rst Y"}, Y, 0);
    check({tag, " rst Empty"}, Empty, 1);
    check({tag, " rst Full"}, Full, 0);
    check({tag, " rst Wrap"}, Wrap, 0);
    check({tag, " rst Err"}, Err, 0);
    @(posedge Clk);
    nReset = 1'b0;
    m_y = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input bit l, input bit r, input bit c, input bit b,
                            input bit ce, input int a_v, input int off_v);
    int soff;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (l) begin
      m_y = a_v;
    end else if (STACK_EN && r) begin
      if (m_stk.size() > 0) m_y = m_stk.pop_back();
      else m_err = 1'b1;
    end else if (STACK_EN && c) begin
      if (m_stk.size() < TB_DEPTH) begin
        m_stk.push_back((m_y + TB_STEP) % 256);
        m_y = a_v;
      end else begin
        m_err = 1'b1;
      end
    end else if (b) begin
      soff = (off_v >= 128) ? off_v - 256 : off_v;
      m_y = (((m_y + soff) % 256) + 256) % 256;
    end else if (ce) begin
      m_wrap = (m_y + TB_STEP) > 255;
      m_y = (m_y + TB_STEP) % 256;
    end
  endtask

  initial begin
    // Directed table: count, wrap, branch, priority and hold.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h03, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h00, 8'hFE, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hF8, 8'h08, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 8'hF8, 8'h55, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h33, 8'h55, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h02, 8'h57, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0};

    #1;
    check("init rst Y", Y, 0);
    check("init rst Empty", Empty, 1);
    check("init rst Full", Full, 0);
    check("init rst Wrap", Wrap, 0);
    check("init rst Err", Err, 0);
    @(posedge Clk);
    nReset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].load, vecs[i].ret, vecs[i].call, vecs[i].branch, vecs[i].counten,
            vecs[i].a, vecs[i].offset);
      check($sformatf("vec%0d Y", i), Y, vecs[i].exp_y);
      check($sformatf("vec%0d Wrap", i), Wrap, vecs[i].exp_wrap);
      check($sformatf("vec%0d Err", i), Err, 0);
      check($sformatf("vec%0d Full", i), Full, 0);
      check($sformatf("vec%0d Empty", i), Empty, 1);
    end
    idle_inputs();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("wrap one-cycle", Wrap, 0);

`ifdef PC_SEQUENCER_STACK_EN
    // Overflow / underflow sequence with DEPTH=2.
    do_reset("ovf");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
    check("call1 Y", Y, 8'h40); check("call1 Err", Err, 0); check("call1 Full", Full, 0);
    check("call1 Empty", Empty, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h60, 8'h00);
    check("call2 Y", Y, 8'h60); check("call2 Err", Err, 0); check("call2 Full", Full, 1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00);
    check("call3 Y", Y, 8'h60); check("call3 Err", Err, 1); check("call3 Full", Full, 1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("ret1 Y", Y, 8'h41); check("ret1 Err", Err, 0); check("ret1 Full", Full, 0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("ret2 Y", Y, 8'h21); check("ret2 Err", Err, 0); check("ret2 Empty", Empty, 1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("ret3 Y", Y, 8'h21); check("ret3 Err", Err, 1); check("ret3 Empty", Empty, 1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    check("after ret3 Err", Err, 0);

    // Reset mid-sequence drops the stack contents.
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h50, 8'h00);
    check("pre-rst Full", Full, 1);
    idle_inputs();
    do_reset("mid");
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("post-rst ret Err", Err, 1);
    check("post-rst ret Y", Y, 0);
    check("post-rst Empty", Empty, 1);
`else
    // Call/Ret ignored without the stack; priority falls through.
    do_reset("nostk");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h00);
    check("nostk call Y", Y, 8'h06); check("nostk call Err", Err, 0);
    check("nostk Full", Full, 0); check("nostk Empty", Empty, 1);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03);
    check("nostk ret Y", Y, 8'h09); check("nostk ret Err", Err, 0);
`endif

    // Random stimulus against the reference model.
    idle_inputs();
    do_reset("rnd");
    for (int n = 0; n < 400; n++) begin
      bit l, r, c, b, ce;
      logic [7:0] a_v, off_v;
      if (n % 97 == 96) begin
        idle_inputs();
        do_reset("rnd-mid");
      end
      l  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 3) == 0);
      ce = ($urandom_range(0, 1) == 0);
      a_v = 8'($urandom);
      off_v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a_v = 8'hFF;
      model_step(l, r, c, b, ce, int'(a_v), int'(off_v));
      apply(l, r, c, b, ce, a_v, off_v);
      check($sformatf("rnd%0d Y", n), Y, m_y);
      check($sformatf("rnd%0d Wrap", n), Wrap, m_wrap);
      check($sformatf("rnd%0d Err", n), Err, m_err);
      check($sformatf("rnd%0d Full", n), Full, STACK_EN && (m_stk.size() == TB_DEPTH));
      check($sformatf("rnd%0d Empty", n), Empty, !STACK_EN || (m_stk.size() == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
